// File: rtl/intpol2_pkg.sv
// Shared defaults and helpers for the interpolator output buffer.
package intpol2_pkg;

   localparam int DEF_DATA_W    = 16;
   localparam int DEF_ADDR_W    = 4;
   localparam int DEF_AF_MARGIN = 2;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) result++;
      return result;
   endfunction

endpackage

// File: rtl/intpol2_out_fifo_if.sv
// Write-strobe, stream and status bundle between the interpolator control and the output buffer.
interface intpol2_out_fifo_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 4
);
   logic              clear;
   logic              wr_en;
   logic [DATA_W-1:0] wr_data;
   logic              afull;
   logic              full;
   logic [DATA_W-1:0] m_data;
   logic              m_valid;
   logic              m_ready;
   logic              empty;
   logic [ADDR_W:0]   level;
   logic              ovf;

   modport master (
      output clear, wr_en, wr_data, m_ready,
      input  afull, full, m_data, m_valid, empty, level, ovf
   );

   modport slave (
      input  clear, wr_en, wr_data, m_ready,
      output afull, full, m_data, m_valid, empty, level, ovf
   );
endinterface

// File: rtl/intpol2_fifo_mem.sv
// Sample storage: synchronous write, asynchronous read, contents not reset.
module intpol2_fifo_mem
   import intpol2_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = 16
) (
   input  logic                    clk,
   input  logic                    we,
   input  logic [clog2(DEPTH)-1:0] waddr,
   input  logic [DATA_W-1:0]       wdata,
   input  logic [clog2(DEPTH)-1:0] raddr,
   output logic [DATA_W-1:0]       rdata
);
   logic [DATA_W-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) r_mem[waddr] <= wdata;
   end

   assign rdata = r_mem[raddr];
endmodule

// File: rtl/intpol2_out_fifo.sv
// First-word-fall-through output buffer: RAM plus one output register, with
// a bypass so a write into an empty buffer is visible after one edge.
module intpol2_out_fifo
   import intpol2_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int AF_MARGIN = DEF_AF_MARGIN
) (
   input  logic         clk,
   input  logic         rstn,
   intpol2_out_fifo_if.slave bus
);
   localparam int              DEPTH = 1 << ADDR_W;
   localparam int              CAP   = DEPTH + 1;
   localparam logic [ADDR_W:0] CAP_L = (ADDR_W+1)'(CAP);
   localparam logic [ADDR_W:0] AF_L  = (ADDR_W+1)'(CAP - AF_MARGIN);

   logic [ADDR_W:0]   r_level;
   logic              r_valid;
   logic [DATA_W-1:0] r_data;
   logic              r_ovf;
   logic [ADDR_W-1:0] r_wr_ptr;
   logic [ADDR_W-1:0] r_rd_ptr;

   logic [ADDR_W:0]   w_ram_cnt;
   logic              w_full;
   logic              w_push;
   logic              w_pop;
   logic              w_load;
   logic              w_from_ram;
   logic              w_bypass;
   logic              w_ram_we;
   logic [DATA_W-1:0] w_ram_rdata;
   logic [ADDR_W:0]   w_level_next;

   // The output register holds one sample of the level; the rest lives in RAM.
   assign w_ram_cnt    = r_level - {{ADDR_W{1'b0}}, r_valid};
   assign w_full       = (r_level == CAP_L);
   assign w_push       = bus.wr_en && !w_full;
   assign w_pop        = r_valid && bus.m_ready;
   assign w_load       = !r_valid || w_pop;
   assign w_from_ram   = w_load && (w_ram_cnt != '0);
   assign w_bypass     = w_load && (w_ram_cnt == '0) && w_push;
   assign w_ram_we     = w_push && !w_bypass && !bus.clear;
   assign w_level_next = r_level + (ADDR_W+1)'(w_push) - (ADDR_W+1)'(w_pop);

   intpol2_fifo_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_mem (
      .clk   (clk),
      .we    (w_ram_we),
      .waddr (r_wr_ptr),
      .wdata (bus.wr_data),
      .raddr (r_rd_ptr),
      .rdata (w_ram_rdata)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_level  <= '0;
         r_valid  <= 1'b0;
         r_data   <= '0;
         r_ovf    <= 1'b0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else if (bus.clear) begin
         // m_data deliberately keeps its old value; only validity is dropped.
         r_level  <= '0;
         r_valid  <= 1'b0;
         r_ovf    <= 1'b0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (bus.wr_en && w_full) r_ovf <= 1'b1;
         if (w_ram_we)   r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_from_ram) r_rd_ptr <= r_rd_ptr + 1'b1;
         r_level <= w_level_next;
         if (w_load) begin
            r_valid <= w_from_ram || w_bypass;
            if (w_from_ram)    r_data <= w_ram_rdata;
            else if (w_bypass) r_data <= bus.wr_data;
         end
      end
   end

   assign bus.level   = r_level;
   assign bus.full    = w_full;
   assign bus.afull   = (r_level >= AF_L);
   assign bus.empty   = (r_level == '0);
   assign bus.m_valid = r_valid;
   assign bus.m_data  = r_data;
   assign bus.ovf     = r_ovf;
endmodule

// File: tb/tb_intpol2_out_fifo.sv
// Scoreboard bench for intpol2_out_fifo: accepted writes are queued, the
// monitor checks every valid output against the queue head on the falling edge.
module tb_intpol2_out_fifo;
   import intpol2_pkg::*;

   logic clk;
   logic rstn;

   intpol2_out_fifo_if #(.DATA_W(16), .ADDR_W(4)) bus ();

   intpol2_out_fifo #(.DATA_W(16), .ADDR_W(4), .AF_MARGIN(2)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [15:0] sb_q[$];

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Every valid head must match the scoreboard head, which also catches hold violations.
   always @(negedge clk) begin
      if (rstn && bus.m_valid) begin
         check_eq("sb_pending", 32'(sb_q.size() != 0), 32'd1);
         if (sb_q.size() != 0) begin
            check_eq("m_data", 32'(bus.m_data), 32'(sb_q[0]));
            if (bus.m_ready) begin
               $display("[TB] pop 0x%04h (expected 0x%04h)", bus.m_data, sb_q[0]);
               void'(sb_q.pop_front());
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [15:0] d, input bit accept);
      bus.wr_en   = 1'b1;
      bus.wr_data = d;
      if (accept) sb_q.push_back(d);
      tick();
      bus.wr_en   = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      bus.m_ready = 1'b1;
      while (bus.level != 0 && n < 200) begin
         tick();
         n++;
      end
      check_eq("drain_level", 32'(bus.level), 32'd0);
      bus.m_ready = 1'b0;
      check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
   endtask

   initial begin
      int sent;
      int cyc;
      rstn        = 1'b0;
      bus.clear   = 1'b0;
      bus.wr_en   = 1'b0;
      bus.wr_data = '0;
      bus.m_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rstn = 1'b1;
      tick();

      check_eq("rst_level", 32'(bus.level), 32'd0);
      check_eq("rst_empty", 32'(bus.empty), 32'd1);
      check_eq("rst_valid", 32'(bus.m_valid), 32'd0);
      check_eq("rst_afull", 32'(bus.afull), 32'd0);
      check_eq("rst_full", 32'(bus.full), 32'd0);
      check_eq("rst_ovf", 32'(bus.ovf), 32'd0);
      check_eq("rst_data", 32'(bus.m_data), 32'd0);

      // Single write: visible after one edge.
      wr(16'h1234, 1'b1);
      check_eq("single_valid", 32'(bus.m_valid), 32'd1);
      check_eq("single_data", 32'(bus.m_data), 32'h1234);
      check_eq("single_level", 32'(bus.level), 32'd1);
      drain();

      // Fill to capacity, then one dropped write.
      for (int i = 0; i < 17; i++) begin
         wr(16'(i + 1), 1'b1);
         check_eq("fill_level", 32'(bus.level), 32'(i + 1));
         check_eq("fill_afull", 32'(bus.afull), 32'((i + 1) >= 15));
         check_eq("fill_full", 32'(bus.full), 32'((i + 1) == 17));
      end
      check_eq("fill_ovf0", 32'(bus.ovf), 32'd0);
      wr(16'hBEEF, 1'b0);
      check_eq("drop_ovf", 32'(bus.ovf), 32'd1);
      check_eq("drop_level", 32'(bus.level), 32'd17);
      drain();
      check_eq("ovf_sticky", 32'(bus.ovf), 32'd1);
      bus.clear = 1'b1;
      tick();
      bus.clear = 1'b0;
      check_eq("clear_ovf", 32'(bus.ovf), 32'd0);

      // Continuous stream through the bypass path.
      bus.m_ready = 1'b1;
      for (int i = 0; i < 100; i++) begin
         wr(16'(i), 1'b1);
         check_eq("stream_level", 32'(bus.level), 32'd1);
         check_eq("stream_valid", 32'(bus.m_valid), 32'd1);
      end
      tick();
      check_eq("stream_end_level", 32'(bus.level), 32'd0);
      check_eq("stream_ovf", 32'(bus.ovf), 32'd0);
      bus.m_ready = 1'b0;

      // Random back-pressure, writes throttled by afull.
      sent = 0;
      cyc  = 0;
      while (sent < 500 && cyc < 5000) begin
         bus.m_ready = 1'($urandom_range(0, 1));
         if (!bus.afull) begin
            wr(16'(sent) ^ 16'hA5A5, 1'b1);
            sent++;
         end else begin
            tick();
         end
         cyc++;
      end
      check_eq("rand_sent", 32'(sent), 32'd500);
      drain();
      check_eq("rand_ovf", 32'(bus.ovf), 32'd0);

      // Pointer wrap: three fill/drain rounds.
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 16; i++) begin
            bus.m_ready = 1'($urandom_range(0, 1));
            wr(16'(16'h1000 * (r + 1) + i), 1'b1);
         end
         drain();
      end
      check_eq("wrap_ovf", 32'(bus.ovf), 32'd0);

      // Flush at level 9 with ovf set.
      for (int i = 0; i < 17; i++) wr(16'(16'h2000 + i), 1'b1);
      wr(16'hBEEF, 1'b0);
      bus.m_ready = 1'b1;
      repeat (8) tick();
      bus.m_ready = 1'b0;
      check_eq("pre_flush_level", 32'(bus.level), 32'd9);
      check_eq("pre_flush_ovf", 32'(bus.ovf), 32'd1);
      bus.clear   = 1'b1;
      bus.wr_en   = 1'b1;
      bus.wr_data = 16'hDEAD;
      bus.m_ready = 1'b1;
      tick();
      sb_q.delete();
      bus.clear   = 1'b0;
      bus.wr_en   = 1'b0;
      bus.m_ready = 1'b0;
      check_eq("flush_level", 32'(bus.level), 32'd0);
      check_eq("flush_valid", 32'(bus.m_valid), 32'd0);
      check_eq("flush_ovf", 32'(bus.ovf), 32'd0);
      check_eq("flush_empty", 32'(bus.empty), 32'd1);
      wr(16'h5A5A, 1'b1);
      check_eq("post_flush_valid", 32'(bus.m_valid), 32'd1);
      check_eq("post_flush_data", 32'(bus.m_data), 32'h5A5A);
      check_eq("post_flush_level", 32'(bus.level), 32'd1);
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
